// File: rtl/pipe_ctrl.sv
// pipe_ctrl: hazard / stall / flush controller for a five-stage pipeline.
// Resolves taken jumps, load-use hazards, multi-cycle mul/div occupancy and
// data-memory wait states into per-register stall and flush controls.
// It also keeps saturating counts of stall cycles and flush cycles.
//
// Memory handshake: mem_req is held high by the MEM stage for as long as an
// access is outstanding. mem_ready is high in the cycle the access
// completes. A cycle with mem_req=1 and mem_ready=0 is a wait cycle. During
// a wait cycle the whole pipeline freezes and the FSM does not advance.
module pipe_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_jmp,
  input  logic             md_start,
  input  logic             md_done,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             clr_cnt,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             id_ex_stall,
  output logic             ex_mem_stall,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_bubble,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             fsm_state
);

  typedef enum logic {
    RUN     = 1'b0,
    MD_BUSY = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t state;
  state_t state_nxt;
  logic   mem_hold;
  logic   load_use;

  // Debug view of the FSM: 0 = RUN, 1 = MD_BUSY.
  assign fsm_state = state;

  assign mem_hold = mem_req && !mem_ready;

  // x0 is hard-wired to zero, so a load targeting x0 never creates a hazard.
  assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                    ((id_rs1_used && (id_rs1 == ex_rd)) ||
                     (id_rs2_used && (id_rs2 == ex_rd)));

  // Control outputs and next state decoded from current state and inputs.
  always_comb begin
    pc_stall      = 1'b0;
    if_id_stall   = 1'b0;
    id_ex_stall   = 1'b0;
    ex_mem_stall  = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_bubble = 1'b0;
    state_nxt     = state;
    if (rst) begin
      state_nxt = RUN;
    end else if (mem_hold) begin
      // Memory wait freezes everything; a coincident md_done is not consumed.
      pc_stall     = 1'b1;
      if_id_stall  = 1'b1;
      id_ex_stall  = 1'b1;
      ex_mem_stall = 1'b1;
    end else begin
      case (state)
        RUN: begin
          if (ex_jmp) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end else if (md_start) begin
            pc_stall      = 1'b1;
            if_id_stall   = 1'b1;
            id_ex_stall   = 1'b1;
            ex_mem_bubble = 1'b1;
            state_nxt     = MD_BUSY;
          end else if (load_use) begin
            // The bubble lets the load reach MEM so the dependent can forward.
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_flush = 1'b1;
          end
        end
        MD_BUSY: begin
          if (md_done) begin
            state_nxt = RUN;
          end else begin
            pc_stall      = 1'b1;
            if_id_stall   = 1'b1;
            id_ex_stall   = 1'b1;
            ex_mem_bubble = 1'b1;
          end
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  // FSM state register; reset returns to RUN even mid mul/div.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // Saturating performance counters with synchronous clear taking priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (clr_cnt) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (pc_stall && (stall_cnt != CNT_MAX)) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      if (if_id_flush && (flush_cnt != CNT_MAX)) begin
        flush_cnt <= flush_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: scoreboard bench for pipe_ctrl. Directed scenarios and
// random traffic are driven one cycle at a time. A reference model
// predicts each cycle's response. A monitor compares the response on the
// falling edge.
module tb_pipe_ctrl;

  localparam int CNT_W = 5;
  localparam int EW    = 7 + 1 + 2 * CNT_W;
  localparam logic [CNT_W-1:0] CMAX = {CNT_W{1'b1}};

  logic             clk;
  logic             rst;
  logic [4:0]       id_rs1, id_rs2, ex_rd;
  logic             id_rs1_used, id_rs2_used;
  logic             ex_mem_read, ex_jmp, md_start, md_done;
  logic             mem_req, mem_ready, clr_cnt;
  logic             pc_stall, if_id_stall, id_ex_stall, ex_mem_stall;
  logic             if_id_flush, id_ex_flush, ex_mem_bubble;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic             fsm_state;

  pipe_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_jmp(ex_jmp),
    .md_start(md_start), .md_done(md_done),
    .mem_req(mem_req), .mem_ready(mem_ready), .clr_cnt(clr_cnt),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall),
    .id_ex_stall(id_ex_stall), .ex_mem_stall(ex_mem_stall),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .ex_mem_bubble(ex_mem_bubble),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
    .fsm_state(fsm_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: "multiply/divide in flight" flag plus integer counters.
  bit m_busy = 1'b0;
  int m_sc   = 0;
  int m_fc   = 0;
  int cmax_i = int'(CMAX);

  // True when the instruction in ID reads the register the EX load writes.
  function automatic bit reads_load_target();
    logic [4:0] srcs[$];
    if (!ex_mem_read || ex_rd == 5'd0) return 1'b0;
    if (id_rs1_used) srcs.push_back(id_rs1);
    if (id_rs2_used) srcs.push_back(id_rs2);
    foreach (srcs[i]) if (srcs[i] == ex_rd) return 1'b1;
    return 1'b0;
  endfunction

  // Predicts this cycle's response from the model, then advances the model
  // across the next rising edge.
  task automatic predict_and_advance();
    bit pc, fi, fe, fm, fl1, fl2, bb;
    bit freeze, whole_stall;
    pc = 0; fi = 0; fe = 0; fm = 0; fl1 = 0; fl2 = 0; bb = 0;
    if (rst) begin
      m_busy = 1'b0; m_sc = 0; m_fc = 0;
    end
    freeze = mem_req && !mem_ready;
    // "whole_stall" = front end held and a bubble sent into EX-MEM.
    whole_stall = 0;
    if (!rst) begin
      if (freeze) begin
        pc = 1; fi = 1; fe = 1; fm = 1;
      end else if (m_busy) begin
        whole_stall = !md_done;
      end else if (ex_jmp) begin
        fl1 = 1; fl2 = 1;
      end else if (md_start) begin
        whole_stall = 1;
      end else if (reads_load_target()) begin
        pc = 1; fi = 1; fl2 = 1;
      end
      if (whole_stall) begin
        pc = 1; fi = 1; fe = 1; bb = 1;
      end
    end
    exp_q.push_back({pc, fi, fe, fm, fl1, fl2, bb, m_busy,
                     CNT_W'(m_sc), CNT_W'(m_fc)});
    // Advance across the next rising edge.
    if (rst) begin
      m_busy = 1'b0; m_sc = 0; m_fc = 0;
    end else begin
      if (clr_cnt) begin
        m_sc = 0; m_fc = 0;
      end else begin
        if (pc  && m_sc < cmax_i) m_sc++;
        if (fl1 && m_fc < cmax_i) m_fc++;
      end
      if (!freeze) begin
        if (m_busy && md_done) m_busy = 1'b0;
        else if (!m_busy && !ex_jmp && md_start) m_busy = 1'b1;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    id_rs1 = 0; id_rs2 = 0; ex_rd = 0;
    id_rs1_used = 0; id_rs2_used = 0;
    ex_mem_read = 0; ex_jmp = 0; md_start = 0; md_done = 0;
    mem_req = 0; mem_ready = 0; clr_cnt = 0;
  endtask

  // Caller sets inputs first; this records the expectation and spends one cycle.
  task automatic cycle();
    predict_and_advance();
    @(posedge clk);
    #2;
    cyc++;
  endtask

  task automatic random_inputs();
    id_rs1      = 5'($urandom_range(0, 3));
    id_rs2      = 5'($urandom_range(0, 3));
    ex_rd       = 5'($urandom_range(0, 3));
    id_rs1_used = ($urandom_range(0, 1) == 1);
    id_rs2_used = ($urandom_range(0, 1) == 1);
    ex_mem_read = ($urandom_range(0, 1) == 1);
    ex_jmp      = ($urandom_range(0, 99) < 15);
    md_start    = ($urandom_range(0, 99) < 20);
    md_done     = ($urandom_range(0, 99) < 30);
    mem_req     = ($urandom_range(0, 99) < 30);
    mem_ready   = ($urandom_range(0, 1) == 1);
    clr_cnt     = ($urandom_range(0, 99) < 3);
    rst         = ($urandom_range(0, 99) < 2);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [EW-1:0] e;
    logic [6:0]    g_ctrl;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g_ctrl = {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
                if_id_flush, id_ex_flush, ex_mem_bubble};
      total += 4;
      if (g_ctrl !== e[EW-1 -: 7]) begin
        bad++;
        $display("FAIL ctrl cyc=%0d got=%b exp=%b", cyc, g_ctrl, e[EW-1 -: 7]);
      end
      if (fsm_state !== e[2*CNT_W]) begin
        bad++;
        $display("FAIL state cyc=%0d got=%b exp=%b", cyc, fsm_state, e[2*CNT_W]);
      end
      if (stall_cnt !== e[2*CNT_W-1 -: CNT_W]) begin
        bad++;
        $display("FAIL stall_cnt cyc=%0d got=%0d exp=%0d", cyc, stall_cnt,
                 e[2*CNT_W-1 -: CNT_W]);
      end
      if (flush_cnt !== e[CNT_W-1:0]) begin
        bad++;
        $display("FAIL flush_cnt cyc=%0d got=%0d exp=%0d", cyc, flush_cnt,
                 e[CNT_W-1:0]);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int wait_cnt;
    idle_inputs();
    rst = 1'b1;
    @(posedge clk);
    #2;
    // Reset, with busy inputs that must be ignored.
    ex_jmp = 1; md_start = 1; mem_req = 1;
    cycle();
    idle_inputs();
    cycle();
    rst = 1'b0;
    cycle();

    // Load-use on rs2, then the same with ex_rd=x0.
    ex_mem_read = 1; ex_rd = 5; id_rs2 = 5; id_rs2_used = 1;
    cycle();
    idle_inputs();
    cycle();
    ex_mem_read = 1; ex_rd = 0; id_rs2 = 0; id_rs2_used = 1;
    cycle();
    idle_inputs();
    // Jump beats a simultaneous load-use.
    ex_jmp = 1; ex_mem_read = 1; ex_rd = 7; id_rs1 = 7; id_rs1_used = 1;
    cycle();
    idle_inputs();
    cycle();

    // mul/div lasting four stall cycles.
    md_start = 1;
    cycle();
    md_start = 0;
    ex_jmp = 1;
    cycle();
    ex_jmp = 0;
    cycle();
    cycle();
    md_done = 1;
    cycle();
    md_done = 0;
    cycle();

    // Memory wait during MD_BUSY swallows an md_done; it is re-presented later.
    md_start = 1;
    cycle();
    md_start = 0;
    mem_req = 1; mem_ready = 0;
    cycle();
    md_done = 1;
    cycle();
    md_done = 0;
    cycle();
    mem_req = 0;
    cycle();
    md_done = 1;
    cycle();
    idle_inputs();
    cycle();

    // Reset in the middle of MD_BUSY.
    md_start = 1;
    cycle();
    md_start = 0;
    cycle();
    rst = 1; ex_jmp = 1; mem_req = 1;
    cycle();
    cycle();
    rst = 0;
    idle_inputs();
    cycle();

    // Drive both counters into saturation, then clear.
    md_start = 1;
    cycle();
    md_start = 0;
    for (int i = 0; i < 40; i++) cycle();
    md_done = 1;
    cycle();
    md_done = 0;
    ex_jmp = 1;
    for (int i = 0; i < 40; i++) cycle();
    ex_jmp = 0;
    clr_cnt = 1;
    cycle();
    clr_cnt = 0;
    cycle();

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      random_inputs();
      cycle();
    end
    rst = 0;
    idle_inputs();
    cycle();

    // Let the monitor drain the queue, with a bounded wait.
    wait_cnt = 0;
    while (exp_q.size() > 0 && wait_cnt < 20) begin
      @(posedge clk);
      wait_cnt++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d left exp=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
